// File: rtl/ttl_universal_register.sv
// ttl_universal_register
// WIDTH-bit register with active-low clock enable and eight operating modes:
// hold, parallel load, shift left/right, rotate left/right, increment, decrement.
// carry is registered alongside q. zero and tc are combinational views of q so
// a neighbouring instance can react within the same cycle when cascaded.
module ttl_universal_register #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             serial_in,
    output logic [WIDTH-1:0] q,
    output logic             carry,
    output logic             zero,
    output logic             tc
);

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_LOAD = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_SHR  = 3'b011,
        MODE_ROL  = 3'b100,
        MODE_ROR  = 3'b101,
        MODE_INC  = 3'b110,
        MODE_DEC  = 3'b111
    } mode_e;

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             carry_q;
    logic             carry_d;

    // Next-state decode: everything holds unless the enable is asserted (low).
    always_comb begin
        q_d     = q_q;
        carry_d = carry_q;
        if (!enable) begin
            case (mode)
                MODE_HOLD: begin
                    q_d     = q_q;
                    carry_d = carry_q;
                end
                MODE_LOAD: begin
                    q_d     = d;
                    carry_d = 1'b0;
                end
                MODE_SHL: begin
                    q_d     = {q_q[WIDTH-2:0], serial_in};
                    carry_d = q_q[WIDTH-1];
                end
                MODE_SHR: begin
                    q_d     = {serial_in, q_q[WIDTH-1:1]};
                    carry_d = q_q[0];
                end
                MODE_ROL: begin
                    q_d     = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                    carry_d = q_q[WIDTH-1];
                end
                MODE_ROR: begin
                    q_d     = {q_q[0], q_q[WIDTH-1:1]};
                    carry_d = q_q[0];
                end
                MODE_INC: begin
                    q_d     = q_q + ONE;
                    carry_d = (q_q == ALL_ONES);
                end
                MODE_DEC: begin
                    q_d     = q_q - ONE;
                    carry_d = (q_q == ALL_ZERO);
                end
                default: begin
                    q_d     = q_q;
                    carry_d = carry_q;
                end
            endcase
        end
    end

    // State register; synchronous reset wins over enable and mode.
    always_ff @(posedge clock) begin
        if (reset) begin
            q_q     <= RESET_VALUE;
            carry_q <= 1'b0;
        end else begin
            q_q     <= q_d;
            carry_q <= carry_d;
        end
    end

    assign q     = q_q;
    assign carry = carry_q;
    assign zero  = (q_q == ALL_ZERO);

    // Terminal count is raised the cycle before a wrap so the next stage up
    // can take ~tc as its enable and step on the same edge as the wrap.
    assign tc = ~enable & (((mode == MODE_INC) & (q_q == ALL_ONES)) |
                           ((mode == MODE_DEC) & (q_q == ALL_ZERO)));

endmodule

// File: tb/tb_ttl_universal_register.sv
// Bench for ttl_universal_register: vector table through a scoreboard queue,
// a rotate-ring sequence, and a two-instance cascade with mid-count reset.
module tb_ttl_universal_register;

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_LOAD = 3'b001;
    localparam logic [2:0] M_SHL  = 3'b010;
    localparam logic [2:0] M_SHR  = 3'b011;
    localparam logic [2:0] M_ROL  = 3'b100;
    localparam logic [2:0] M_ROR  = 3'b101;
    localparam logic [2:0] M_INC  = 3'b110;
    localparam logic [2:0] M_DEC  = 3'b111;

    typedef struct {
        logic       rst;
        logic       en;
        logic [2:0] md;
        logic [7:0] d;
        logic       si;
        logic [7:0] q;
        logic       c;
        logic       z;
        logic       tc;
    } vec_t;

    typedef struct {
        logic [7:0] q;
        logic       c;
        logic       z;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic [2:0] mode;
    logic [7:0] d;
    logic       serial_in;
    logic [7:0] q;
    logic       carry;
    logic       zero;
    logic       tc;

    logic       c_rst;
    logic [2:0] c_mode;
    logic       lo_en;
    logic       hi_en_ext;
    logic       casc_sel;
    logic       hi_en;
    logic [7:0] lo_d;
    logic [7:0] hi_d;
    logic [7:0] lo_q;
    logic [7:0] hi_q;
    logic       lo_c;
    logic       hi_c;
    logic       lo_z;
    logic       hi_z;
    logic       lo_tc;
    logic       hi_tc;

    int total = 0;
    int bad   = 0;

    exp_t        sb[$];
    logic [15:0] casc_sb[$];
    vec_t        vecs[23];

    always #5 clock = ~clock;

    assign hi_en = casc_sel ? ~lo_tc : hi_en_ext;

    ttl_universal_register #(.WIDTH(8), .RESET_VALUE(8'h5A)) dut (
        .clock(clock), .reset(reset), .enable(enable), .mode(mode), .d(d),
        .serial_in(serial_in), .q(q), .carry(carry), .zero(zero), .tc(tc)
    );

    ttl_universal_register #(.WIDTH(8), .RESET_VALUE(8'h5A)) u_lo (
        .clock(clock), .reset(c_rst), .enable(lo_en), .mode(c_mode), .d(lo_d),
        .serial_in(1'b0), .q(lo_q), .carry(lo_c), .zero(lo_z), .tc(lo_tc)
    );

    ttl_universal_register #(.WIDTH(8), .RESET_VALUE(8'h5A)) u_hi (
        .clock(clock), .reset(c_rst), .enable(hi_en), .mode(c_mode), .d(hi_d),
        .serial_in(1'b0), .q(hi_q), .carry(hi_c), .zero(hi_z), .tc(hi_tc)
    );

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Drive one vector on the falling edge, check tc before the rising edge,
    // then compare registered outputs against the queued expectation.
    task automatic apply(input vec_t v, input string nm);
        exp_t e;
        @(negedge clock);
        reset     = v.rst;
        enable    = v.en;
        mode      = v.md;
        d         = v.d;
        serial_in = v.si;
        #1;
        chk({nm, ".tc"}, {15'd0, tc}, {15'd0, v.tc});
        sb.push_back('{v.q, v.c, v.z});
        @(posedge clock);
        #1;
        e = sb.pop_front();
        chk({nm, ".q"}, {8'd0, q}, {8'd0, e.q});
        chk({nm, ".carry"}, {15'd0, carry}, {15'd0, e.c});
        chk({nm, ".zero"}, {15'd0, zero}, {15'd0, e.z});
    endtask

    task automatic casc_check(input string nm);
        logic [15:0] e;
        @(posedge clock);
        #1;
        e = casc_sb.pop_front();
        chk(nm, {hi_q, lo_q}, e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t       v;
        logic [7:0] e;

        //          rst   en    mode    d      si    q      c     z     tc
        vecs[0]  = '{1'b1, 1'b1, M_LOAD, 8'hFF, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, M_LOAD, 8'h80, 1'b0, 8'h80, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, M_LOAD, 8'h11, 1'b0, 8'h80, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, M_LOAD, 8'h81, 1'b0, 8'h81, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, M_SHL,  8'h00, 1'b0, 8'h02, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, M_SHR,  8'h00, 1'b1, 8'h81, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, M_LOAD, 8'h01, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, M_ROR,  8'h00, 1'b0, 8'h80, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, M_ROL,  8'h00, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, M_SHL,  8'h00, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, M_HOLD, 8'hAA, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, M_LOAD, 8'hFE, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b0, M_INC,  8'h00, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b0, M_INC,  8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
        vecs[14] = '{1'b0, 1'b0, M_DEC,  8'h00, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 1'b0, M_DEC,  8'h00, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 1'b0, M_LOAD, 8'hFF, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 1'b1, M_INC,  8'h00, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0};
        vecs[18] = '{1'b0, 1'b0, M_INC,  8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
        vecs[19] = '{1'b1, 1'b0, M_INC,  8'h00, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0};
        vecs[20] = '{1'b0, 1'b0, M_SHR,  8'h00, 1'b0, 8'h2D, 1'b0, 1'b0, 1'b0};
        vecs[21] = '{1'b0, 1'b0, M_SHL,  8'h00, 1'b1, 8'h5B, 1'b0, 1'b0, 1'b0};
        vecs[22] = '{1'b0, 1'b0, M_DEC,  8'h00, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0};

        reset     = 1'b1;
        enable    = 1'b1;
        mode      = M_HOLD;
        d         = 8'h00;
        serial_in = 1'b0;
        c_rst     = 1'b1;
        c_mode    = M_HOLD;
        lo_en     = 1'b1;
        hi_en_ext = 1'b1;
        casc_sel  = 1'b0;
        lo_d      = 8'h00;
        hi_d      = 8'h00;

        for (int i = 0; i < 23; i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Eight rotates left bring a single set bit back to where it started.
        v = '{1'b0, 1'b0, M_LOAD, 8'h01, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0};
        apply(v, "rol_load");
        e = 8'h01;
        for (int i = 0; i < 8; i++) begin
            v    = '{1'b0, 1'b0, M_ROL, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
            v.c  = e[7];
            e    = {e[6:0], e[7]};
            v.q  = e;
            v.z  = (e == 8'h00);
            apply(v, $sformatf("rol%0d", i));
        end
        chk("rol_ring_final", {8'd0, q}, 16'h0001);

        // Cascade: preload lower=FF, upper=00 with independent enables.
        @(negedge clock);
        c_rst     = 1'b0;
        casc_sel  = 1'b0;
        hi_en_ext = 1'b0;
        lo_en     = 1'b0;
        c_mode    = M_LOAD;
        lo_d      = 8'hFF;
        hi_d      = 8'h00;
        casc_sb.push_back(16'h00FF);
        casc_check("casc_load");

        @(negedge clock);
        casc_sel = 1'b1;
        c_mode   = M_INC;
        #1;
        chk("casc_lo_tc_pre_wrap", {15'd0, lo_tc}, 16'd1);
        casc_sb.push_back(16'h0100);
        casc_check("casc_wrap");
        chk("casc_lo_carry", {15'd0, lo_c}, 16'd1);

        @(negedge clock);
        #1;
        chk("casc_lo_tc_after", {15'd0, lo_tc}, 16'd0);
        casc_sb.push_back(16'h0101);
        casc_check("casc_step");

        @(negedge clock);
        c_rst = 1'b1;
        casc_sb.push_back(16'h5A5A);
        casc_check("casc_reset");
        chk("casc_carry_reset", {14'd0, hi_c, lo_c}, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
